// File: rtl/rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rx_pkg
//  Purpose  : Shared types and constants for the receive frame deserializer.
//             State encoding, default sync pattern and counter widths.
//  Revision : 1.0  initial release
// ============================================================================
package rx_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } rx_state_t;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;
    localparam int         BYTE_W            = 8;
    localparam int         BYTE_CNT_W        = 9;

endpackage
`default_nettype wire

// File: rtl/rx_sync_match.sv
`default_nettype none
// ============================================================================
//  Module   : rx_sync_match
//  Purpose  : Serial shift register plus sync-word detector.
//  Ports    : clk_high, rst (async, active-low)
//             sample_en, din  - bit strobe and serial data
//             hunt            - detector armed (FSM in HUNT)
//             clear           - end of frame: empty register, restart fill
//             sreg            - registered shift contents
//             shifted         - {sreg[6:0], din}, value after this strobe
//             hit             - combinational match on this strobe
//             match           - registered copy of hit (frame_start timing)
//  Revision : 1.0  initial release
// ============================================================================
module rx_sync_match
    import rx_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
    input  logic              clk_high,
    input  logic              rst,
    input  logic              sample_en,
    input  logic              din,
    input  logic              hunt,
    input  logic              clear,
    output logic [BYTE_W-1:0] sreg,
    output logic [BYTE_W-1:0] shifted,
    output logic              hit,
    output logic              match
);

    // Saturates at 8; only the >=7 threshold matters, so 4 bits suffice.
    logic [3:0] fill_cnt;

    assign shifted = {sreg[BYTE_W-2:0], din};

    // The fill gate stops a short pattern from matching against the zeros
    // left in the register after reset or after a frame ends.
    assign hit = hunt && sample_en && (fill_cnt >= 4'd7) && (shifted == SYNC_WORD);

    always_ff @(posedge clk_high or negedge rst) begin
        if (!rst) begin
            sreg     <= '0;
            fill_cnt <= 4'd0;
            match    <= 1'b0;
        end else begin
            match <= hit;
            if (clear) begin
                sreg     <= '0;
                fill_cnt <= 4'd0;
            end else if (sample_en) begin
                sreg <= shifted;
                if (hunt && fill_cnt != 4'd8) begin
                    fill_cnt <= fill_cnt + 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rx_frame_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : rx_frame_deserializer
//  Purpose  : Hunts for a sync word on a strobed serial line, then assembles
//             a length-prefixed frame of MSB-first bytes.
//  Ports    : clk_high, rst (async, active-low), sample_en, din, frame_len
//             byte_out/byte_valid - assembled byte and its one-cycle strobe
//             frame_start         - pulse on sync detect
//             frame_done          - pulse with the last byte of a frame
//             sync_lock           - level, high while not hunting
//             parity_err          - only when RX_PARITY_CHECK_EN is defined
//  Options  : RX_PARITY_CHECK_EN adds an even-parity bit after each byte.
//  Revision : 1.0  initial release
// ============================================================================
module rx_frame_deserializer
    import rx_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEFAULT,
    parameter int         DATA_W    = BYTE_W
) (
    input  logic              clk_high,
    input  logic              rst,
    input  logic              sample_en,
    input  logic              din,
    input  logic [7:0]        frame_len,
    output logic [DATA_W-1:0] byte_out,
    output logic              byte_valid,
    output logic              frame_start,
    output logic              frame_done,
`ifdef RX_PARITY_CHECK_EN
    output logic              parity_err,
`endif
    output logic              sync_lock
);

    rx_state_t             state;
    logic [2:0]            bit_cnt;
    logic [BYTE_CNT_W-1:0] byte_cnt;

    logic [BYTE_W-1:0]     sreg;
    logic [BYTE_W-1:0]     shifted;
    logic                  hit;
    logic                  frame_end;
    logic                  last_byte;

    assign last_byte = (byte_cnt == 9'd1);

`ifdef RX_PARITY_CHECK_EN
    assign frame_end = sample_en && (state == PARITY) && last_byte;
`else
    assign frame_end = sample_en && (state == DATA) && (bit_cnt == 3'd7) && last_byte;
    // Only the parity path needs the pre-shift register contents.
    logic [BYTE_W-1:0] unused_sreg;
    assign unused_sreg = sreg;
`endif

    rx_sync_match #(
        .SYNC_WORD (SYNC_WORD)
    ) u_sync (
        .clk_high  (clk_high),
        .rst       (rst),
        .sample_en (sample_en),
        .din       (din),
        .hunt      (state == HUNT),
        .clear     (frame_end),
        .sreg      (sreg),
        .shifted   (shifted),
        .hit       (hit),
        .match     (frame_start)
    );

    always_ff @(posedge clk_high or negedge rst) begin
        if (!rst) begin
            state      <= HUNT;
            bit_cnt    <= 3'd0;
            byte_cnt   <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
            sync_lock  <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
            if (hit) begin
                state     <= DATA;
                sync_lock <= 1'b1;
                bit_cnt   <= 3'd0;
                byte_cnt  <= (frame_len == 8'd0) ? 9'd256 : {1'b0, frame_len};
            end else if (sample_en) begin
                case (state)
                    DATA: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef RX_PARITY_CHECK_EN
                            state <= PARITY;
`else
                            byte_out   <= shifted;
                            byte_valid <= 1'b1;
                            byte_cnt   <= byte_cnt - 9'd1;
                            if (last_byte) begin
                                frame_done <= 1'b1;
                                sync_lock  <= 1'b0;
                                state      <= HUNT;
                            end
`endif
                        end
                    end
`ifdef RX_PARITY_CHECK_EN
                    PARITY: begin
                        // sreg still holds the data byte; din is its parity bit.
                        byte_out   <= sreg;
                        byte_valid <= 1'b1;
                        parity_err <= ^{sreg, din};
                        byte_cnt   <= byte_cnt - 9'd1;
                        if (last_byte) begin
                            frame_done <= 1'b1;
                            sync_lock  <= 1'b0;
                            state      <= HUNT;
                        end else begin
                            state <= DATA;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
